// File: rtl/reg_file_arbiter.sv
// ---------------------------------------------------------------------------
// reg_file_arbiter
//
// Shares the single-port reg_file between NUM_REQ requesters. A single
// transaction is in flight at a time. The arbiter holds the grant until the
// granted requester has accepted the reg_file result. Every command, including
// WRITE and MARKD, finishes with a result handshake.
//
// Optional feature macro: REG_ARB_WB_PRIO_EN
//   defined   : requester 0 (writeback) wins every arbitration it takes part
//               in. The other requesters rotate among themselves.
//   undefined : plain round-robin over all requesters.
//
// Ports
//   clk           system clock, all logic on posedge
//   reset         synchronous active-low reset
//   req_valid     per-requester command valid
//   req_ready     per-requester command accepted (one-hot pulse, IDLE only)
//   req_reg       4-bit register index, slice k for requester k
//   req_cmd       2-bit command, slice k
//   req_data      write data, slice k
//   rsp_valid     per-requester result valid (granted bit only)
//   rsp_ready     per-requester result accept
//   rsp_data      shared result bus
//   rf_reg/rf_cmd/rf_data/rf_valid   command side towards reg_file
//   rf_res_ready  result accept towards reg_file
//   rf_rdata/rf_res_valid/rf_ready   from reg_file
//   grant         index of the current or most recent grant
//
// FSM states
//   state    | meaning
//   ST_IDLE  | arbitrating; req_ready pulses for the winner
//   ST_ISSUE | rf_valid high with the latched command, waiting rf_ready
//   ST_RESP  | result passed through to the granted requester
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module reg_file_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [4*NUM_REQ-1:0]          req_reg,
    input  logic [2*NUM_REQ-1:0]          req_cmd,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [3:0]                    rf_reg,
    output logic [1:0]                    rf_cmd,
    output logic [DATA_WIDTH-1:0]         rf_data,
    output logic                          rf_valid,
    output logic                          rf_res_ready,
    input  logic [DATA_WIDTH-1:0]         rf_rdata,
    input  logic                          rf_res_valid,
    input  logic                          rf_ready,
    output logic [1:0]                    grant
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0] state;
    logic [1:0] rr_ptr;
    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;
    logic [1:0] grant_next;
    logic       rsp_done;

    // Scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
`ifdef REG_ARB_WB_PRIO_EN
        if (req_valid[0]) begin
            found  = 1'b1;
            winner = 2'd0;
        end else begin
            // Requester 0 is handled above, so the rotation skips it.
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = 2'((int'(rr_ptr) + i) % NUM_REQ);
                if (!found && idx != 2'd0 && req_valid[idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = 2'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
`endif
    end

    assign grant_next = (int'(grant) == NUM_REQ - 1) ? 2'd0 : grant + 2'd1;
    assign rsp_done   = rf_res_valid && rsp_ready[grant];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= 2'd0;
            grant   <= 2'd0;
            rf_reg  <= '0;
            rf_cmd  <= '0;
            rf_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        rf_reg  <= req_reg[int'(winner)*4 +: 4];
                        rf_cmd  <= req_cmd[int'(winner)*2 +: 2];
                        rf_data <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        grant   <= winner;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rf_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_done) begin
                        state <= ST_IDLE;
`ifdef REG_ARB_WB_PRIO_EN
                        // Priority grants to requester 0 leave the rotation alone.
                        if (grant != 2'd0) begin
                            rr_ptr <= grant_next;
                        end
`else
                        rr_ptr <= grant_next;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are gated with reset. During a synchronous reset the FSM may
    // still sit in a non-reset state, and no handshake may leak out then.
    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_data     = '0;
        rf_res_ready = 1'b0;
        rf_valid     = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        req_ready[winner] = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    rf_valid = 1'b1;
                end
                ST_RESP: begin
                    rsp_valid[grant] = rf_res_valid;
                    rsp_data         = rf_rdata;
                    rf_res_ready     = rsp_ready[grant];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
Shares the single-port `reg_file` between NUM_REQ requesters, e.g. decode (read/check), execute (mark dirty) and writeback (write). Each requester uses the same command/valid/ready and result handshake that `reg_file` exposes. The arbiter grants one transaction at a time, round-robin, and holds the grant until the granted requester consumes the `reg_file` result. It then routes that result back to the granted requester only.

Parameters:
NUM_REQ, 3, number of requesters (2..4); requester 0 is writeback by convention.
DATA_WIDTH, `DATA_WIDTH from header.v, register data width.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-low reset (reset==0 resets).
req_valid  input  NUM_REQ  per-requester command valid.
req_ready  output  NUM_REQ  per-requester command accepted (one-hot, one-cycle pulse).
req_reg  input  4*NUM_REQ  register index, slice k for requester k.
req_cmd  input  2*NUM_REQ  REG_CMD_READ/WRITE/MARKD/CHECK, slice k.
req_data  input  DATA_WIDTH*NUM_REQ  write data, slice k.
rsp_valid  output  NUM_REQ  result valid, only the granted bit can be 1.
rsp_ready  input  NUM_REQ  requester accepts the result.
rsp_data  output  DATA_WIDTH  shared result bus, meaningful only with rsp_valid.
rf_reg  output  4  to reg_file i_reg.
rf_cmd  output  2  to reg_file i_cmd.
rf_data  output  DATA_WIDTH  to reg_file i_data.
rf_valid  output  1  to reg_file i_valid.
rf_res_ready  output  1  to reg_file i_res_ready.
rf_rdata  input  DATA_WIDTH  from reg_file o_data.
rf_res_valid  input  1  from reg_file o_res_valid.
rf_ready  input  1  from reg_file o_ready.
grant  output  2  index of the current or last grant, for debug.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, rr_ptr=0, grant=0.
  - rf_valid=0, rf_res_ready=0, req_ready=0, rsp_valid=0, rf_reg/rf_cmd/rf_data/rsp_data=0.
  - Reset mid-transaction abandons it; no req_ready or rsp_valid is produced for it.
  - The top level drives reg_file reset from the same net, inverted, so both sides restart together.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Winner = first k with req_valid[k], scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - If a winner exists: req_ready[winner]=1 combinationally in IDLE. At that edge latch req_reg/req_cmd/req_data of the winner into rf_*, set grant=winner, go to ISSUE.
  - No winner: stay in IDLE.
- ISSUE:
  - rf_valid=1 with the latched fields held stable.
  - At an edge with rf_ready=1, the transfer occurs; go to RESP with rf_valid=0 next cycle.
- RESP:
  - rsp_valid[grant]=rf_res_valid, rsp_data=rf_rdata, rf_res_ready=rsp_ready[grant] (all combinational pass-through).
  - At an edge with rf_res_valid && rsp_ready[grant]: go to IDLE, rr_ptr=(grant+1) mod NUM_REQ.
- Every command, including WRITE and MARKD, completes through RESP. Writers must accept the result (data is don't-care).
- Minimum occupancy is 3 cycles per transaction; the earliest next grant is in the cycle after RESP exits.
- Simultaneous requests: exactly one req_ready bit per grant. Losers keep req_valid high, and their fields may change while waiting.
- req_valid dropped before grant: that request is simply not considered.
- rsp_ready on non-granted bits is ignored.
- Back-to-back requests from a single requester are allowed; rotation never starves a continuously valid requester. Worst-case wait is NUM_REQ-1 grants.
- req_ready is never asserted outside IDLE.

Optional Feature:
REG_ARB_WB_PRIO_EN
- Defined: requester 0 wins IDLE arbitration whenever req_valid[0]=1, regardless of rr_ptr. The other requesters rotate among themselves. rr_ptr is not advanced by requester-0 grants.
- Undefined: pure round-robin over all requesters, as above.

Test Plan:
- Reset held low 2 cycles with all req_valid=1 → req_ready=0, rf_valid=0, rsp_valid=0; the first grant after release goes to requester 0.
- Requester 1 only: WRITE reg 2 data 0x1234, then READ reg 2 → rsp_data=0x1234 on rsp_valid[1]. The only rf_valid pulses are the two ISSUE phases.
- All three valid continuously, each READ → grant sequence 0,1,2,0,1,2. Exactly one req_ready per grant. No rsp_valid on non-granted bits.
- rsp_ready[grant] held low 5 cycles in RESP → FSM holds RESP, rsp_valid stays high, rf_res_ready=0, no new grant until accepted.
- Reset asserted while in ISSUE for MARKD reg 0 → next cycle state IDLE and rf_valid=0. A following CHECK reg 0 returns data=0.
- With REG_ARB_WB_PRIO_EN, requesters 0 and 2 continuously valid → requester 0 wins every grant. With the macro undefined, grants alternate 0,2,0,2.
